// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: widths, opcode and state encodings for the RAM burst controller
package ram_ctrl_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 4;
  localparam int DEPTH = 64;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_FILL = 2'b10, OP_RSVD = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, WRITE, READ, FILL} state_t;
endpackage

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: sequences WRITE/READ/FILL bursts onto a single-port RAM with a registered read stream
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_fill,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t            state;
  logic [ADDR_W-1:0] addr, len, cnt;
  logic [DATA_W-1:0] fill;
  logic              last, drain, issue, wr_fire;
  assign cmd_ready = state == IDLE;
  assign wr_ready  = state == WRITE;
  assign drain     = rd_valid && rd_ready;
  // a read is only issued when the output register can take the word this edge
  assign issue     = state == READ && !last && (!rd_valid || rd_ready);
  assign wr_fire   = (state == WRITE && wr_valid) || state == FILL;
  // gating with rst_n keeps a burst cut by reset from landing one more word
  assign ram_en    = rst_n && (wr_fire || issue);
  assign ram_rw    = !(rst_n && wr_fire);
  assign ram_addr  = addr;
  assign ram_din   = state == WRITE ? wr_data : state == FILL ? fill : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      len      <= '0;
      cnt      <= '0;
      fill     <= '0;
      last     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE && cmd_valid) begin
        if (cmd_op == OP_RSVD) err <= 1'b1;
        else begin
          state <= cmd_op == OP_WRITE ? WRITE : cmd_op == OP_READ ? READ : FILL;
          addr  <= cmd_addr;
          len   <= cmd_len;
          fill  <= cmd_fill;
          cnt   <= '0;
          last  <= 1'b0;
          busy  <= 1'b1;
        end
      end
      if (wr_fire || issue) begin
        addr <= addr + 1'b1;
        cnt  <= cnt + 1'b1;
      end
      if (wr_fire && cnt == len) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
      if (issue) begin
        rd_data  <= ram_dout;
        rd_valid <= 1'b1;
        last     <= cnt == len;
      end else if (drain) rd_valid <= 1'b0;
      // a read burst ends only once its final word leaves the output register
      if (state == READ && last && drain) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed and random bursts checked against a scoreboard image of the RAM
module tb_ram_burst_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [5:0] cmd_addr = '0, cmd_len = '0;
  logic [3:0] cmd_fill = '0, wr_data = '0;
  logic       cmd_ready, wr_ready, rd_valid, ram_en, ram_rw, busy, done, err;
  logic [3:0] rd_data, ram_din;
  logic [5:0] ram_addr;
  wire  [3:0] ram_dout;
  logic       init_en = 1'b0;
  logic [5:0] init_addr = '0;
  logic [3:0] init_data = '0;
  logic [3:0] mem [64];
  logic [3:0] ref_mem [64];
  int checks = 0, errors = 0;

  ram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_fill(cmd_fill), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign ram_dout = (ram_en && ram_rw) ? mem[ram_addr] : 4'bz;
  always @(posedge clk)
    if (ram_en && !ram_rw) mem[ram_addr] <= ram_din;
    else if (init_en) mem[init_addr] <= init_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk(tag, {busy, done, err, rd_valid, rd_data, wr_ready, ram_en, ram_rw, ram_addr, ram_din},
        {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 6'h0, 4'h0});
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] a, input logic [5:0] len,
                         input logic [3:0] f, input int stall_pct, input int gap_at,
                         input int rdy_mode, input bit chain, input string nm);
    logic [3:0] wq[$];
    logic [3:0] got[$];
    logic [3:0] held = '0;
    bit hold = 0, fin = 0;
    logic chain_err = 1'b0;
    int n = int'(len) + 1;
    int wi = 0, nw = 0, ndone = 0, nerr = 0, bad = 0, unstable = 0, gap = 2, mism = 0;
    int acc = -1, done_c = -1, last_ev = -1, first_rv = -1;
    for (int i = 0; i < n; i++) wq.push_back(gap_at >= 0 ? 4'(i + 1) : 4'($urandom));
    cmd_op = op; cmd_addr = a; cmd_len = len; cmd_fill = f; cmd_valid = 1'b1;
    for (int c = 0; c < 600 && !fin; c++) begin
      wr_data  = wi < n ? wq[wi] : 4'h0;
      wr_valid = wi < n && $urandom_range(99) >= stall_pct;
      if (acc >= 0 && wi == gap_at && gap > 0) begin
        wr_valid = 1'b0;
        gap--;
      end
      rd_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (c % 2 == 0) : 1'($urandom_range(1));
      @(negedge clk);
      if (cmd_valid && cmd_ready && acc < 0) acc = c;
      if (busy && cmd_ready) bad++;
      if (!busy && (ram_en || !ram_rw || wr_ready)) bad++;
      if (op == 2'b11 && busy) bad++;
      if (rd_valid && !rd_ready && ram_en) bad++;
      if (hold && !(rd_valid && rd_data == held)) unstable++;
      hold = rd_valid && !rd_ready;
      held = rd_data;
      if (ram_en && !ram_rw) begin nw++; last_ev = c; end
      if (wr_valid && wr_ready) wi++;
      if (rd_valid && first_rv < 0) first_rv = c;
      if (rd_valid && rd_ready) begin got.push_back(rd_data); last_ev = c; end
      if (done) begin
        ndone++;
        done_c = c;
        fin = 1;
        chk({nm, "_busy_at_done"}, busy, 1'b0);
        chk({nm, "_ready_at_done"}, cmd_ready, 1'b1);
      end
      if (err) begin
        nerr++;
        if (op == 2'b11) fin = 1;
      end
      @(posedge clk); #1;
      if (acc == c) begin
        if (chain) cmd_op = 2'b11;
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (chain && t == 0) chain_err = err;
      else if (err) nerr++;
      if (done) ndone++;
      if (ram_en) bad++;
      @(posedge clk); #1;
    end
    if (op == 2'b00 || op == 2'b10)
      for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 64] = op == 2'b10 ? f : wq[i];
    chk({nm, "_finished"}, fin, 1'b1);
    chk({nm, "_nwrites"}, nw, (op == 2'b00 || op == 2'b10) ? n : 0);
    chk({nm, "_mem"}, mem_diffs(), 0);
    chk({nm, "_done_count"}, ndone, op == 2'b11 ? 0 : 1);
    chk({nm, "_err_count"}, nerr, op == 2'b11 ? 1 : 0);
    chk({nm, "_protocol"}, bad, 0);
    if (chain) chk({nm, "_chain_accept"}, chain_err, 1'b1);
    if (op != 2'b11) chk({nm, "_done_lat"}, done_c - last_ev, 1);
    if (op == 2'b01) begin
      for (int i = 0; i < got.size(); i++) if (got[i] !== ref_mem[(int'(a) + i) % 64]) mism++;
      chk({nm, "_rd_count"}, got.size(), n);
      chk({nm, "_rd_data"}, mism, 0);
      chk({nm, "_rd_stable"}, unstable, 0);
      if (rdy_mode == 0) begin
        chk({nm, "_rd_latency"}, first_rv - acc, 2);
        chk({nm, "_rd_rate"}, last_ev - first_rv, int'(len));
      end
    end
  endtask

  task automatic fill_reset();
    logic [5:0] a = 6'($urandom);
    logic [3:0] f = 4'($urandom);
    int nw = 0;
    cmd_op = 2'b10; cmd_addr = a; cmd_len = 6'd9; cmd_fill = f; cmd_valid = 1'b1;
    @(negedge clk);
    chk("rfill_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ram_en && !ram_rw) nw++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rfill_en_in_rst", ram_en, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outs("rfill_rst_outs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) ref_mem[(int'(a) + i) % 64] = f;
    chk("rfill_nwrites", nw, 2);
    chk("rfill_mem", mem_diffs(), 0);
    @(negedge clk);
    chk("rfill_ready_after", cmd_ready, 1'b1);
    chk("rfill_no_done", done, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    init_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      init_addr = 6'(i);
      init_data = 4'($urandom);
      ref_mem[i] = init_data;
    end
    @(posedge clk); #1;
    init_en = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset_outs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_mem", mem_diffs(), 0);
    @(posedge clk); #1;
    run_cmd(2'b10, 6'h3C, 6'd7, 4'hA, 0, -1, 0, 1'b0, "fill_wrap");
    run_cmd(2'b01, 6'h3C, 6'd7, 4'h0, 0, -1, 0, 1'b0, "read_wrap");
    run_cmd(2'b00, 6'($urandom), 6'd3, 4'h0, 0, 2, 0, 1'b0, "write_stall");
    run_cmd(2'b01, 6'($urandom), 6'd4, 4'h0, 0, -1, 1, 1'b0, "read_bp");
    run_cmd(2'b11, 6'($urandom), 6'($urandom), 4'($urandom), 0, -1, 0, 1'b0, "rsvd");
    fill_reset();
    run_cmd(2'b01, 6'($urandom), 6'($urandom), 4'h0, 0, -1, 0, 1'b0, "after_rst");
    run_cmd(2'b10, 6'($urandom), 6'd5, 4'($urandom), 0, -1, 0, 1'b1, "held_cmd");
    for (int k = 0; k < 14; k++)
      run_cmd($urandom_range(9) == 0 ? 2'b11 : 2'($urandom_range(2)), 6'($urandom),
              6'($urandom), 4'($urandom), 30, -1, 2, 1'b0, $sformatf("rand%0d", k));
    run_cmd(2'b01, 6'h00, 6'd63, 4'h0, 0, -1, 0, 1'b0, "read_full");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
